// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM with a BCD mm:ss counter advanced by an upstream one-second tick.
// Optional lap-freeze display is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned MIN_LIMIT = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic        enable,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  // state | meaning
  // IDLE  | time zeroed, waiting for start_stop
  // RUN   | time advancing, display shows live time
  // LAP   | time advancing, display frozen on lap register
  // PAUSE | time held, clear returns to IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
`ifdef STOPWATCH_LAP_EN
    S_LAP   = 2'd2,
`endif
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] MIN_T_MAX = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_O_MAX = 4'(MIN_LIMIT % 10);

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [15:0] disp_q, disp_d;
  logic        wrap_q, wrap_d;
  logic        counting;
  logic        at_max;
  logic        zero_time;
  logic        show_lap;

  logic [3:0] min_t, min_o, sec_t, sec_o;
  assign {min_t, min_o, sec_t, sec_o} = time_q;

`ifdef STOPWATCH_LAP_EN
  assign counting   = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_active = (state_q == S_LAP);
  assign show_lap   = (state_d == S_LAP);
`else
  assign counting   = (state_q == S_RUN);
  assign lap_active = 1'b0;
  assign show_lap   = 1'b0;
`endif

  assign enable  = counting;
  assign running = counting;
  assign disp    = disp_q;
  assign wrap    = wrap_q;

  assign at_max = (sec_t == 4'd5) && (sec_o == 4'd9) &&
                  (min_t == MIN_T_MAX) && (min_o == MIN_O_MAX);

  // clear outranks start_stop, which outranks lap, in every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!clear && start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (clear) state_d = S_RUN;
        else if (start_stop) state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap) state_d = S_LAP;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (clear) state_d = S_LAP;
        else if (start_stop) state_d = S_PAUSE;
        else if (lap) state_d = S_RUN;
      end
`endif
      S_PAUSE: begin
        if (clear) state_d = S_IDLE;
        else if (start_stop) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign zero_time = (state_q == S_PAUSE) && (state_d == S_IDLE);

  always_comb begin
    time_d = time_q;
    wrap_d = 1'b0;
    if (zero_time) begin
      time_d = 16'h0000;
    end else if (counting && tick) begin
      if (sec_o != 4'd9) begin
        time_d[3:0] = sec_o + 4'd1;
      end else begin
        time_d[3:0] = 4'd0;
        if (sec_t != 4'd5) begin
          time_d[7:4] = sec_t + 4'd1;
        end else begin
          time_d[7:4] = 4'd0;
          if (at_max) begin
            time_d[15:8] = 8'h00;
            wrap_d       = 1'b1;
          end else if (min_o != 4'd9) begin
            time_d[11:8] = min_o + 4'd1;
          end else begin
            time_d[11:8]  = 4'd0;
            time_d[15:12] = min_t + 4'd1;
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_q, lap_d;

  // the lap register snapshots the time as it stands after the entering edge
  always_comb begin
    lap_d = lap_q;
    if (zero_time) lap_d = 16'h0000;
    else if ((state_q != S_LAP) && (state_d == S_LAP)) lap_d = time_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lap_q <= 16'h0000;
    else      lap_q <= lap_d;
  end

  assign disp_d = show_lap ? lap_d : time_d;
`else
  assign disp_d = show_lap ? 16'h0000 : time_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      time_q  <= 16'h0000;
      disp_q  <= 16'h0000;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      disp_q  <= disp_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: MIN_LIMIT, default 99, highest minute value displayed (legal range 1..99).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: tick  input  1  one-cycle elapsed-second pulse from the upstream count_to_100 timeout.
REQ-005 Port: start_stop  input  1  one-cycle clean command pulse; toggles run/pause.
REQ-006 Port: lap  input  1  one-cycle clean command pulse; freezes or unfreezes the display.
REQ-007 Port: clear  input  1  one-cycle clean command pulse; zeroes the time when paused.
REQ-008 Port: enable  output  1  enable for the upstream count_to_100; high only while time is advancing.
REQ-009 Port: disp  output  16  BCD display {min_tens, min_ones, sec_tens, sec_ones}.
REQ-010 Port: running  output  1  high in RUN or LAP.
REQ-011 Port: lap_active  output  1  high in LAP.
REQ-012 Port: wrap  output  1  one-cycle pulse when the time rolls over to 00:00.

Function
REQ-013 FSM states: IDLE, RUN, LAP, PAUSE, held in a 2-bit state register.
REQ-014 Command priority within one cycle: clear > start_stop > lap; lower-priority pulses are discarded that cycle.
REQ-015 IDLE: start_stop -> RUN; lap and clear ignored.
REQ-016 RUN: start_stop -> PAUSE; lap -> LAP; clear ignored.
REQ-017 LAP: lap -> RUN; start_stop -> PAUSE; clear ignored.
REQ-018 PAUSE: clear -> IDLE; start_stop -> RUN; lap ignored.
REQ-019 enable, running and lap_active are decoded from the current state register, with no extra latency.
REQ-020 Internal time is BCD: seconds 00..59, minutes 00..MIN_LIMIT; each digit never exceeds 9, and sec_tens never exceeds 5.
REQ-021 Internal time increments by one second on tick only if the state before the edge is RUN or LAP.
REQ-022 A tick arriving in the same cycle as a state-changing command is counted according to the pre-transition state.
REQ-023 Seconds carry: at 59 the seconds go to 00 and the minutes increment.
REQ-024 Rollover: on a tick at MIN_LIMIT:59, time goes to 00:00 and wrap is high for exactly the following cycle; the FSM state is unchanged.
REQ-025 Entering LAP captures the live time into a lap register; while in LAP, disp shows the lap register and the live time keeps advancing.
REQ-026 In every state other than LAP, disp shows the live time, registered, updating one cycle after the tick.
REQ-027 Transition PAUSE -> IDLE on clear zeroes the live time and the lap register on the same edge.
REQ-028 Ticks in IDLE or PAUSE are ignored; no other condition alters the time.

Reset
REQ-029 Asserting rst low immediately forces state IDLE, live time 00:00, lap register 00:00, disp 16'h0000, enable 0, running 0, lap_active 0, wrap 0.
REQ-030 Reset mid-operation discards all time; after rst releases, the block waits in IDLE for start_stop.

Configuration
REQ-031 Macro STOPWATCH_LAP_EN: when defined, the LAP state, lap register and lap behaviour are present as specified above.
REQ-032 Without STOPWATCH_LAP_EN, the lap input is ignored, the LAP state and lap register are absent, lap_active is tied 0, and disp always shows the live time.

Verification
REQ-033 Reset, then start_stop, then 75 ticks -> disp = 16'h0115, running = 1, enable = 1.
REQ-034 MIN_LIMIT = 1, run, 120 ticks -> disp = 16'h0000 after tick 120, wrap high for exactly one cycle, state still RUN.
REQ-035 Run 10 ticks, lap, 5 ticks -> disp holds 16'h0010; then lap again -> disp = 16'h0015 next cycle.
REQ-036 Run 3 ticks, then start_stop and tick in the same cycle -> PAUSE with disp = 16'h0004; further ticks leave the time unchanged.
REQ-037 In PAUSE, clear and start_stop in the same cycle -> IDLE, disp = 16'h0000, enable = 0.
REQ-038 Run 30 ticks, assert rst low mid-cycle -> all outputs zero immediately; after release, ticks do not count until start_stop.
